mult_reconstructor: RTL and testbench

- Sequential shift-and-add unit that rebuilds the dividend from a division result: P = Q*B + R.
- Inverse direction of the combinational divisor. Used as a self-check / round-trip stage downstream of the divisor `top`, and as the multiply path of the arithmetic datapath.
- Start/done handshake; one iteration per quotient bit.

---
 rtl/mult_reconstructor.sv | 126 ++++++++++++
 tb/tb_mult_reconstructor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mult_reconstructor.sv
// ---------------------------------------------------------------------------
// mult_reconstructor
//
// Sequential shift-and-add unit that rebuilds a dividend from a division
// result: P = Q*B + R. It works on one quotient bit per clock and uses a
// start/done handshake. The accumulator starts at R, so the remainder costs
// no extra cycle.
//
// Parameters:
//   N      operand width for Q, B and R; P is 2N bits wide
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  operation request, sampled on the rising clk edge
//   Q      quotient operand (multiplier)
//   B      divisor operand (multiplicand)
//   R      remainder operand (addend)
//   ovf    (only with MULT_RECON_OVF_EN) P does not fit in N bits
//   busy   high while the shift-and-add loop runs
//   done   one-cycle pulse; P is valid
//   P      reconstructed result Q*B + R, held until the next completion
//
// Optional feature: define MULT_RECON_OVF_EN to add the registered ovf
// output. It is updated together with P.
// ---------------------------------------------------------------------------
module mult_reconstructor #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   Q,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   R,
`ifdef MULT_RECON_OVF_EN
    output logic           ovf,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [N-1:0]   q_sh;     // Q copy, shifted right once per iteration
    logic [N-1:0]   b_reg;    // latched multiplicand
    logic [2*N-1:0] acc;      // running partial sum, seeded with R
    logic [CW-1:0]  cnt;      // iteration index, also the weight of q_sh[0]
    logic [2*N-1:0] acc_next;
    logic           launch;
    logic           last_iter;

    // busy and done are decodes of the state register, so they are glitch
    // free and carry no combinational path from the inputs.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // A new operation is accepted from IDLE and also from the single DONE
    // cycle, which is what allows back-to-back issue every N+1 cycles.
    assign launch    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == CW'(N - 1));

    always_comb begin
        // NOTE: give every combinational output a value on every path first;
        // a missing assignment on some branch would infer a latch.
        acc_next = acc;
        if (q_sh[0]) begin
            // The multiplicand is widened to 2N before shifting so the high
            // partial-product bits are not lost.
            acc_next = acc + ({{N{1'b0}}, b_reg} << cnt);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state, including the operand copies, is cleared on reset
        // so an aborted operation leaves nothing behind for the next one.
        if (!rst_n) begin
            state <= IDLE;
            q_sh  <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
`ifdef MULT_RECON_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        q_sh  <= Q;
                        b_reg <= B;
                        acc   <= {{N{1'b0}}, R};
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is ignored here; the operands were latched at launch.
                    acc  <= acc_next;
                    q_sh <= q_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last_iter) begin
                        P     <= acc_next;
`ifdef MULT_RECON_OVF_EN
                        ovf   <= |acc_next[2*N-1:N];
`endif
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_reconstructor.sv
// ---------------------------------------------------------------------------
// tb_mult_reconstructor
//
// Self-checking bench for mult_reconstructor. The expected result of every
// operation is plain integer arithmetic Q*B + R, and the expected cycle
// behaviour is the N-cycle busy window followed by a single done cycle.
// Directed cases cover the handshake corners; a randomized loop covers the
// operand space with random back-to-back issue and mid-run start pokes.
// ---------------------------------------------------------------------------
module tb_mult_reconstructor;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   Q;
    logic [N-1:0]   B;
    logic [N-1:0]   R;
    logic           busy;
    logic           done;
    logic [2*N-1:0] P;
`ifdef MULT_RECON_OVF_EN
    logic           ovf;
`endif

    int errors = 0;
    int checks = 0;
    int prev_p = 0;   // last completed result; P must hold it between dones

    mult_reconstructor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Q     (Q),
        .B     (B),
        .R     (R),
`ifdef MULT_RECON_OVF_EN
        .ovf   (ovf),
`endif
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: present operands with start high, so the next
    // rising edge is the launch edge t0; start drops right after it.
    task automatic launch(input int q, input int b, input int r);
        Q     = N'(q);
        B     = N'(b);
        R     = N'(r);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        Q     = N'($urandom);
        B     = N'($urandom);
        R     = N'($urandom);
    endtask

    // Follows an operation launched by launch(): N busy cycles with P held,
    // then the done cycle with the new result. Returns at the done negedge.
    // With poke set, start is raised mid-run with other operands.
    task automatic finish_op(input int exp, input bit poke);
        for (int i = 1; i <= N; i++) begin
            @(negedge clk);
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("p_hold", P, prev_p);
            if (poke && i == 2) begin
                start = 1'b1;
                Q     = N'($urandom);
                B     = N'($urandom);
                R     = N'($urandom);
            end
            if (poke && i == 3) start = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("p_result", P, exp);
`ifdef MULT_RECON_OVF_EN
        check("ovf", ovf, (exp >= (1 << N)) ? 1 : 0);
`endif
        prev_p = exp;
    endtask

    // One cycle after done with no new start: idle, single pulse, P held.
    task automatic idle_check();
        @(negedge clk);
        check("done_once", done, 0);
        check("busy_idle", busy, 0);
        check("p_idle", P, prev_p);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        Q     = '0;
        B     = '0;
        R     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_p", P, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 13 / 4 round trip, then back-to-back issue from the DONE cycle
        launch(3, 4, 1);
        finish_op(13, 1'b0);
        launch(2, 5, 1);
        finish_op(11, 1'b0);
        idle_check();

        // Boundary operands: maximum values, zero multiplier, zero multiplicand
        launch(15, 15, 15);
        finish_op(240, 1'b0);
        idle_check();
        launch(0, 9, 5);
        finish_op(5, 1'b0);
        idle_check();
        launch(7, 0, 2);
        finish_op(2, 1'b0);
        idle_check();

        // start re-asserted mid-run with other operands is ignored
        launch(6, 7, 3);
        finish_op(45, 1'b1);
        idle_check();

        // Overflow indication: 23 does not fit in 4 bits, 7 does
        launch(5, 4, 3);
        finish_op(23, 1'b0);
        idle_check();
        launch(2, 3, 1);
        finish_op(7, 1'b0);
        launch(3, 4, 1);
        finish_op(13, 1'b0);
        idle_check();

        // Asynchronous abort in RUN cycle 2: outputs clear at once, no done
        launch(9, 9, 9);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_p", P, 0);
`ifdef MULT_RECON_OVF_EN
        check("abort_ovf", ovf, 0);
`endif
        prev_p = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end

        // Randomized operands with random back-to-back issue and pokes
        for (int n = 0; n < 40; n++) begin
            int q, b, r;
            q = $urandom_range(0, (1 << N) - 1);
            b = $urandom_range(0, (1 << N) - 1);
            r = $urandom_range(0, (1 << N) - 1);
            launch(q, b, r);
            finish_op(q * b + r, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
